// File: rtl/apb_req_arbiter_if.sv
// APB-side bundle between apb_req_arbiter and the APB master/slave path.
// master: arbiter side (drives select/address/data); slave: responder side.
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              transfer;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA1;
    logic [DATA_W-1:0] PRDATA2;

    modport master (
        output PSEL, transfer, PWRITE, PADDR, PDATA,
        input  PREADY, PRDATA1, PRDATA2
    );

    modport slave (
        input  PSEL, transfer, PWRITE, PADDR, PDATA,
        output PREADY, PRDATA1, PRDATA2
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the APB master.
// Optional PREADY wait limit enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [2*DATA_W-1:0] rdata,
    output logic                err,
    apb_req_arbiter_if.master   apb
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state;
    logic   last_sel;   // requester served most recently; reset to 1 so req0 wins first
    logic   cur_sel;
    logic   pick;
    logic   timed_out;
    logic   busy_end;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    always_comb begin
        pick = req1 && (!req0 || !last_sel);
    end

    always_comb begin
        timed_out = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        timed_out = !apb.PREADY && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif
        busy_end = apb.PREADY || timed_out;
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state        <= S_IDLE;
            last_sel     <= 1'b1;
            cur_sel      <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata        <= '0;
            apb.PSEL     <= 1'b0;
            apb.transfer <= 1'b0;
            apb.PWRITE   <= 1'b0;
            apb.PADDR    <= '0;
            apb.PDATA    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            err          <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        cur_sel      <= pick;
                        gnt0         <= !pick;
                        gnt1         <= pick;
                        apb.PADDR    <= pick ? addr1  : addr0;
                        apb.PWRITE   <= pick ? wr1    : wr0;
                        apb.PDATA    <= pick ? wdata1 : wdata0;
                        apb.PSEL     <= 1'b1;
                        apb.transfer <= 1'b1;
                        state        <= S_BUSY;
`ifdef APB_ARB_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (busy_end) begin
                        // Completion (normal or timed out) is reported in DONE.
                        if (apb.PREADY && !apb.PWRITE)
                            rdata <= {apb.PRDATA1, apb.PRDATA2};
                        apb.PSEL     <= 1'b0;
                        apb.transfer <= 1'b0;
                        apb.PWRITE   <= 1'b0;
                        gnt0         <= 1'b0;
                        gnt1         <= 1'b0;
                        done0        <= !cur_sel;
                        done1        <= cur_sel;
                        state        <= S_DONE;
`ifdef APB_ARB_TIMEOUT_EN
                        err          <= timed_out;
`endif
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    last_sel <= cur_sel;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef APB_ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter with a 4-cycle PREADY slave.
module tb_apb_req_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_err    = 0;

    logic       stall = 1'b0;
    logic [3:0] scnt;
    logic       saw_g0;

    apb_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) apb_if ();

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .apb(apb_if)
    );

    always #5 PCLK = ~PCLK;

    // Slave: PREADY on the 4th cycle of PSEL.
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)            scnt <= '0;
        else if (apb_if.PSEL)   scnt <= scnt + 1'b1;
        else                    scnt <= '0;
    end
    assign apb_if.PREADY = apb_if.PSEL && (scnt == 4'd3) && !stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the grant cycle (cycle 1); returns cycle index of the done pulse.
    task automatic wait_done(input bit who, output int cyc, output int psel_hi);
        cyc     = 1;
        psel_hi = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            cyc++;
            if (gnt0) saw_g0 = 1'b1;
            if (who ? done1 : done0) return;
            if (apb_if.PSEL) psel_hi++;
        end
        cyc = -1;
    endtask

    int     cyc, phi;
    int     n_done, ng, low_run, min_gap;
    int     order [4];
    logic   prev_psel, overlap, had_xfer;

    initial begin
        PRESET = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        apb_if.PRDATA1 = '0; apb_if.PRDATA2 = '0;
        saw_g0 = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel",  64'(apb_if.PSEL), 64'd0);
        chk("rst_gnt",   64'({gnt0, gnt1}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_paddr", 64'(apb_if.PADDR), 64'd0);
        PRESET = 1'b1;

        // req0 read
        @(negedge PCLK);
        addr0 = 32'h4; req0 = 1;
        apb_if.PRDATA1 = 32'h400921FB; apb_if.PRDATA2 = 32'h54442D18;
        @(negedge PCLK);
        chk("rd0_gnt",   64'({gnt0, gnt1}), 64'b10);
        chk("rd0_psel",  64'({apb_if.PSEL, apb_if.transfer, apb_if.PWRITE}), 64'b110);
        chk("rd0_paddr", 64'(apb_if.PADDR), 64'h4);
        wait_done(1'b0, cyc, phi);
        chk("rd0_lat",   64'(cyc), 64'd5);
        chk("rd0_pselc", 64'(phi), 64'd4);
        chk("rd0_done",  64'({done0, done1, apb_if.PSEL, gnt0, err}), 64'b10000);
        chk("rd0_rdata", rdata, 64'h400921FB54442D18);
        req0 = 0;
        @(negedge PCLK);
        chk("rd0_pulse", 64'({done0, done1}), 64'd0);

        // req1 read
        addr1 = 32'h8; req1 = 1; saw_g0 = 1'b0;
        apb_if.PRDATA1 = 32'h4005BF0A; apb_if.PRDATA2 = 32'h8B145769;
        @(negedge PCLK);
        chk("rd1_gnt",   64'({gnt0, gnt1}), 64'b01);
        chk("rd1_paddr", 64'(apb_if.PADDR), 64'h8);
        wait_done(1'b1, cyc, phi);
        chk("rd1_lat",   64'(cyc), 64'd5);
        chk("rd1_done",  64'({done0, done1, saw_g0}), 64'b010);
        chk("rd1_rdata", rdata, 64'h4005BF0A8B145769);
        req1 = 0;
        @(negedge PCLK);

        // req1 write; slave data changed to prove rdata is not reloaded
        wr1 = 1; wdata1 = 32'hDEADBEEF; addr1 = 32'h4; req1 = 1;
        apb_if.PRDATA1 = 32'h11111111; apb_if.PRDATA2 = 32'h22222222;
        @(negedge PCLK);
        chk("wr1_pwrite", 64'({gnt1, apb_if.PWRITE}), 64'b11);
        chk("wr1_pdata",  64'(apb_if.PDATA), 64'hDEADBEEF);
        chk("wr1_paddr",  64'(apb_if.PADDR), 64'h4);
        wait_done(1'b1, cyc, phi);
        chk("wr1_done",   64'({done1, done0}), 64'b10);
        chk("wr1_rdata",  rdata, 64'h4005BF0A8B145769);
        req1 = 0; wr1 = 0;
        @(negedge PCLK);
        chk("wr1_idle",   64'({apb_if.PSEL, apb_if.PWRITE, apb_if.PDATA}), {32'd0, 32'hDEADBEEF});

        // reset mid-transfer
        req0 = 1; addr0 = 32'h10;
        @(negedge PCLK);
        chk("mr_gnt", 64'(gnt0), 64'd1);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        #1;
        chk("mr_out",   64'({apb_if.PSEL, apb_if.transfer, gnt0, gnt1, done0, done1, err}), 64'd0);
        chk("mr_rdata", rdata, 64'd0);
        chk("mr_paddr", 64'({apb_if.PADDR, apb_if.PDATA}), 64'd0);
        req0 = 0;
        @(negedge PCLK);
        chk("mr_held", 64'({apb_if.PSEL, done0, done1}), 64'd0);

        // both requesters held from reset release: expect 0,1,0,1
        PRESET = 1'b1; req0 = 1; req1 = 1; addr0 = 32'h20; addr1 = 32'h24;
        n_done = 0; ng = 0; low_run = 0; min_gap = 99;
        prev_psel = 1'b0; overlap = 1'b0; had_xfer = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int c = 0; c < 200 && n_done < 4; c++) begin
            @(negedge PCLK);
            if (gnt0 && gnt1) overlap = 1'b1;
            if (apb_if.PSEL && !prev_psel) begin
                if (had_xfer && low_run < min_gap) min_gap = low_run;
                if (ng < 4) begin
                    order[ng] = gnt1 ? 1 : 0;
                    ng++;
                end
                had_xfer = 1'b1;
            end
            low_run   = apb_if.PSEL ? 0 : low_run + 1;
            prev_psel = apb_if.PSEL;
            if (done0 || done1) begin
                n_done++;
                if (n_done == 4) begin
                    req0 = 0; req1 = 0;
                end
            end
        end
        chk("rr_ndone", 64'(n_done), 64'd4);
        chk("rr_ord0",  64'(order[0]), 64'd0);
        chk("rr_ord1",  64'(order[1]), 64'd1);
        chk("rr_ord2",  64'(order[2]), 64'd0);
        chk("rr_ord3",  64'(order[3]), 64'd1);
        chk("rr_gap",   64'(min_gap >= 2), 64'd1);
        chk("rr_onehot", 64'(overlap), 64'd0);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
        // PREADY withheld: timeout after 16 BUSY cycles
        apb_if.PRDATA1 = 32'hAAAAAAAA; apb_if.PRDATA2 = 32'h55555555;
        wr0 = 0; stall = 1; req0 = 1;
        @(negedge PCLK);
        chk("to_gnt", 64'(gnt0), 64'd1);
        begin : to_rdata_snapshot
            logic [63:0] prev_rd;
            prev_rd = rdata;
            wait_done(1'b0, cyc, phi);
            chk("to_lat",   64'(cyc), 64'd17);
            chk("to_err",   64'({done0, err, apb_if.PSEL}), 64'b110);
            chk("to_rdata", rdata, prev_rd);
        end
        req0 = 0; stall = 0;
        @(negedge PCLK);
        chk("to_errpulse", 64'(err), 64'd0);
        req0 = 1;
        @(negedge PCLK);
        wait_done(1'b0, cyc, phi);
        chk("to_next",  64'({cyc[7:0], done0, err}), {8'd5, 2'b10});
        chk("to_nrd",   rdata, 64'hAAAAAAAA55555555);
        req0 = 0;
        repeat (2) @(negedge PCLK);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester round-robin arbiter and sequencer in front of the APB master. It serialises read/write requests from two clients onto the single master/slave path. For each transfer it drives PSEL/transfer/PWRITE/PADDR/PDATA into the master and waits for the slave's PREADY. On a read it captures the 64-bit result from PRDATA1 (upper word) and PRDATA2 (lower word), for example an IEEE-754 double constant, and returns it to the granted client with a one-cycle done pulse.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data word width; the read result is 2*DATA_W
- TIMEOUT, 16, PREADY wait limit in cycles (used only with APB_ARB_TIMEOUT_EN)

- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request; held high until the matching done pulse
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-hot; high from latch until done
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  2*DATA_W  {PRDATA1, PRDATA2} from the last completed read
- err  out  1  one-cycle timeout pulse, coincident with done
- PSEL, transfer, PWRITE  out  1  to the master
- PADDR  out  ADDR_W  to the master
- PDATA  out  DATA_W  to the master
- PREADY  in  1  from the slave
- PRDATA1 / PRDATA2  in  DATA_W  slave read data, upper / lower word

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - With no request pending, all master outputs stay low. PADDR and PDATA hold their last values.
  - If any req is high, select the requester by round-robin. Priority goes to the requester not served last; after reset, req0 has priority.
  - Latch the selected requester's addr, wr and wdata into PADDR, PWRITE and PDATA. Assert its gnt and go to BUSY.
- BUSY:
  - PSEL = 1 and transfer = 1. PADDR, PWRITE and PDATA are held stable.
  - When PREADY is sampled high and PWRITE = 0, load rdata <= {PRDATA1, PRDATA2}. A write leaves rdata unchanged.
  - On PREADY, go to DONE.
- DONE:
  - PSEL = 0 and transfer = 0. Pulse done of the granted requester and drop its gnt.
  - Update the priority pointer, then go to IDLE.
  - This guarantees at least 2 cycles with PSEL low between consecutive transfers (DONE + IDLE).
- Request rules:
  - A req that falls before being granted is ignored.
  - A req that falls after grant does not abort the transfer; done still pulses.
  - A req that stays high after done is a new request.
- Only one gnt is ever high. A done pulse never occurs without a preceding gnt.

## Timing
- Reset: PRESET low immediately forces every output to 0 (PSEL, transfer, PWRITE, PADDR, PDATA, gnt*, done*, rdata, err). The FSM goes to IDLE and priority goes to req0.
- Reset asserted mid-transfer aborts it: no done pulse, rdata not updated.
- req is sampled at edge t in IDLE. gnt and PSEL are high from t+1.
- PREADY is sampled high at edge t+k. Then:
  - DONE occupies cycle t+k+1.
  - done and updated rdata are visible in that cycle.
  - PSEL is low in that cycle.
- Latency from req to done is k+1 cycles. k is set by the master/slave; k = 4 for the existing slave (PSEL high for 4 clocks).
- Simultaneous req0 and req1 held continuously: grants alternate 0, 1, 0, 1…
- PREADY high at the same edge BUSY is entered is not sampled; it is sampled only from the first BUSY cycle onward.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY and clears on entry to BUSY.
  - If TIMEOUT cycles pass without PREADY, the FSM goes to DONE, pulses err with done, and leaves rdata unchanged.
  - The priority pointer still advances.
- APB_ARB_TIMEOUT_EN not defined: BUSY waits indefinitely and err is tied 0.

## Test plan
- PRESET low mid-BUSY → all outputs 0 asynchronously. After release, the first request is served with no spurious done.
- req0 read, addr0 = 0x4; slave returns PRDATA1 = 0x400921FB, PRDATA2 = 0x54442D18 → gnt0, PSEL for 4 clocks, done0 one cycle, rdata = 0x400921FB54442D18.
- req1 read, addr1 = 0x8; slave returns 0x4005BF0A / 0x8B145769 → rdata = 0x4005BF0A8B145769, done1 only, gnt0 never asserted.
- req0 and req1 both held from reset for 4 transfers → grant order 0, 1, 0, 1. Each gap has ≥2 cycles with PSEL = 0, and gnt0 & gnt1 is never 1.
- req1 write, wr1 = 1, wdata1 = 0xDEADBEEF, addr1 = 0x4 → PWRITE = 1, PDATA = 0xDEADBEEF during BUSY, done1 pulses, rdata unchanged.
- With APB_ARB_TIMEOUT_EN and TIMEOUT = 16: PREADY forced 0 → done0 and err pulse together at cycle 17 after grant, rdata unchanged, next request served normally.
